// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential PC generation, multi-outstanding in-order fetch,
// and a FQ_DEPTH-entry queue toward ID. Optional IF_PERF_CNT_EN adds fetch/flush counters.
module if_fetch_queue #(
    parameter int unsigned PC_WIDTH   = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned FQ_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h0000_0000_8000_0000),
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [PC_WIDTH-1:0]   imem_req_pc_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_inst_i,
    output logic                  IF_valid_o,
    output logic [PC_WIDTH-1:0]   IF_pc_o,
    output logic [INST_WIDTH-1:0] IF_inst_o,
    input  logic                  ID_ready_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
`endif
);

    localparam int unsigned IDX_W  = $clog2(FQ_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned DROP_W = IDX_W + 2;

    logic [PTR_W-1:0]    alloc_ptr, fill_ptr, head_ptr;
    logic [PTR_W-1:0]    alloc_n, fill_n, head_n;
    logic [DROP_W-1:0]   drop_cnt, drop_n;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;

    logic [PC_WIDTH-1:0]   pc_mem   [FQ_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [FQ_DEPTH];

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] outstanding;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_fill;
    logic             deq_fire;

    assign occupancy   = alloc_ptr - head_ptr;
    assign outstanding = alloc_ptr - fill_ptr;

    // Request is gated by queue credits, so a dequeue frees a credit only next cycle
    assign imem_req_valid_o = !rst && !redirect_valid_i && (occupancy < PTR_W'(FQ_DEPTH));
    assign imem_req_pc_o    = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Responses owed to flushed requests are swallowed first; extras with nothing outstanding are ignored
    assign rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);
    assign rsp_fill = imem_rsp_valid_i && (drop_cnt == '0) && (fill_ptr != alloc_ptr);

    assign IF_valid_o = (fill_ptr != head_ptr);
    assign IF_pc_o    = pc_mem[head_ptr[IDX_W-1:0]];
    assign IF_inst_o  = inst_mem[head_ptr[IDX_W-1:0]];
    assign deq_fire   = IF_valid_o && ID_ready_i && !redirect_valid_i;

    // Next-state for pointers, drop counter and fetch PC
    always_comb begin
        alloc_n    = alloc_ptr;
        fill_n     = fill_ptr;
        head_n     = head_ptr;
        drop_n     = drop_cnt;
        fetch_pc_n = fetch_pc;
        if (redirect_valid_i) begin
            fill_n     = alloc_ptr;
            head_n     = alloc_ptr;
            drop_n     = drop_cnt + DROP_W'(outstanding)
                         - (rsp_drop ? DROP_W'(1) : '0)
                         - (rsp_fill ? DROP_W'(1) : '0);
            fetch_pc_n = redirect_pc_i;
        end else begin
            if (req_fire) begin
                alloc_n    = alloc_ptr + PTR_W'(1);
                fetch_pc_n = fetch_pc + PC_WIDTH'(PC_STEP);
            end
            if (rsp_drop) drop_n = drop_cnt - DROP_W'(1);
            if (rsp_fill) fill_n = fill_ptr + PTR_W'(1);
            if (deq_fire) head_n = head_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            fetch_pc  <= RESET_PC;
        end else begin
            alloc_ptr <= alloc_n;
            fill_ptr  <= fill_n;
            head_ptr  <= head_n;
            drop_cnt  <= drop_n;
            fetch_pc  <= fetch_pc_n;
        end
    end

    // Entry payload storage; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (req_fire) pc_mem[alloc_ptr[IDX_W-1:0]] <= fetch_pc;
        if (rsp_fill && !redirect_valid_i) inst_mem[fill_ptr[IDX_W-1:0]] <= imem_rsp_inst_i;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (deq_fire)         perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (redirect_valid_i) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: latency-programmable memory model feeding an expected-entry
// scoreboard; a separate monitor checks every ID handshake against it.
module tb_if_fetch_queue;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_pc_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_inst_i;
    logic        IF_valid_o;
    logic [63:0] IF_pc_o;
    logic [31:0] IF_inst_o;
    logic        ID_ready_i;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    if_fetch_queue dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_pc_o    (imem_req_pc_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_inst_i  (imem_rsp_inst_i),
        .IF_valid_o       (IF_valid_o),
        .IF_pc_o          (IF_pc_o),
        .IF_inst_o        (IF_inst_o),
        .ID_ready_i       (ID_ready_i)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int pop_cnt = 0;
    int first_vld_cyc = -1;
    int lat = 1;

    // Shadow controls, applied to DUT inputs at each falling edge
    logic        rst_v = 1'b1;
    logic        redir = 1'b0;
    logic [63:0] rpc = '0;
    logic        mem_rdy = 1'b0;
    logic        id_rdy = 1'b0;
    logic [63:0] exp_pc = RST_PC;

    exp_t        exp_q[$];
    logic [63:0] pend_pc[$];
    int          pend_due[$];

    function automatic logic [31:0] mkinst(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // One cycle: drive inputs and memory response, then record any request handshake
    task automatic step();
        @(negedge clk);
        cyc++;
        rst              = rst_v;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        imem_req_ready_i = mem_rdy;
        ID_ready_i       = id_rdy;
        if (!rst_v && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_inst_i  = mkinst(pend_pc[0]);
            void'(pend_pc.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_inst_i  = '0;
        end
        if (rst_v) begin
            pend_pc.delete();
            pend_due.delete();
            exp_q.delete();
            exp_pc = RST_PC;
        end else if (redir) begin
            exp_q.delete();
            exp_pc = rpc;
        end
        #1;
        if (imem_req_valid_o && imem_req_ready_i) begin
            chk("req_pc", imem_req_pc_o, exp_pc);
            pend_pc.push_back(imem_req_pc_o);
            pend_due.push_back(cyc + lat);
            exp_q.push_back('{pc: exp_pc, inst: mkinst(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            req_cnt++;
        end
    endtask

    task automatic drain();
        bit done;
        done    = 1'b0;
        mem_rdy = 1'b0;
        id_rdy  = 1'b1;
        redir   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            #2;
            done = (exp_q.size() == 0) && (pend_pc.size() == 0);
        end
        chk("drain_left", 64'(exp_q.size() + pend_pc.size()), 64'd0);
        step();
        chk("drain_if_valid", 64'(IF_valid_o), 64'd0);
    endtask

    // Monitor: every ID handshake must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect_valid_i && IF_valid_o) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (ID_ready_i) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL if_unexpected: got pc %h inst %h, required no entry", IF_pc_o, IF_inst_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("if_pc", IF_pc_o, e.pc);
                        chk("if_inst", 64'(IF_inst_o), 64'(e.inst));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, p0, r0, rr;
        rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0; imem_rsp_inst_i = '0; ID_ready_i = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        chk("rst_if_valid", 64'(IF_valid_o), 64'd0);

        // Streaming at 1-cycle latency: first request right after reset, ID sees it 2 cycles later
        rst_v = 1'b0; mem_rdy = 1'b1; id_rdy = 1'b1; lat = 1;
        c0 = cyc + 1; p0 = pop_cnt; r0 = req_cnt;
        repeat (10) step();
        #2;
        chk("stream_req_cnt", 64'(req_cnt - r0), 64'd10);
        chk("first_valid_lat", 64'(first_vld_cyc - c0), 64'd2);
        chk("stream_pop_cnt", 64'(pop_cnt - p0), 64'd8);
        drain();

        // Full queue with ID stalled, then release
        id_rdy = 1'b0; mem_rdy = 1'b1; lat = 1; r0 = req_cnt;
        repeat (8) step();
        chk("full_req_cnt", 64'(req_cnt - r0), 64'd4);
        chk("full_req_valid", 64'(imem_req_valid_o), 64'd0);
        chk("full_if_valid", 64'(IF_valid_o), 64'd1);
        id_rdy = 1'b1;
        step();
        chk("deq_cycle_req_valid", 64'(imem_req_valid_o), 64'd0);
        step();
        chk("after_deq_req_valid", 64'(imem_req_valid_o), 64'd1);
        drain();

        // Redirect with 3 responses still in flight
        lat = 4; mem_rdy = 1'b1; id_rdy = 1'b1; p0 = pop_cnt;
        repeat (3) step();
        redir = 1'b1; rpc = 64'h0000_0000_8000_1000;
        step();
        chk("redir_req_valid", 64'(imem_req_valid_o), 64'd0);
        rr = req_cnt;
        redir = 1'b0;
        step();
        chk("post_redir_req_valid", 64'(imem_req_valid_o), 64'd1);
        chk("post_redir_req_pc", imem_req_pc_o, 64'h0000_0000_8000_1000);
        repeat (4) step();
        drain();
        chk("redir_pop_cnt", 64'(pop_cnt - p0), 64'(req_cnt - rr));

        // Redirect coinciding with a live response
        lat = 3; mem_rdy = 1'b1; id_rdy = 1'b1; p0 = pop_cnt;
        repeat (3) step();
        redir = 1'b1; rpc = 64'h0000_0000_8000_2000;
        step();
        chk("coinc_rsp_valid", 64'(imem_rsp_valid_i), 64'd1);
        rr = req_cnt;
        redir = 1'b0;
        repeat (5) step();
        drain();
        chk("coinc_pop_cnt", 64'(pop_cnt - p0), 64'(req_cnt - rr));

        // PC wrap at the top of the address space
        lat = 1; mem_rdy = 1'b1; id_rdy = 1'b1;
        redir = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redir = 1'b0;
        repeat (3) step();
        chk("wrap_req_pc", imem_req_pc_o, 64'h0);
        repeat (3) step();
        drain();

`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", 64'(perf_fetch_cnt_o), 64'(pop_cnt));
        chk("perf_flush", 64'(perf_flush_cnt_o), 64'd3);
`endif

        // Reset over a full queue and a concurrent redirect
        id_rdy = 1'b0; mem_rdy = 1'b1; lat = 1;
        repeat (6) step();
        chk("pre_rst_full", 64'(imem_req_valid_o), 64'd0);
        rst_v = 1'b1; redir = 1'b1; rpc = 64'h0000_0000_0000_1234;
        step();
        redir = 1'b0;
        step();
        chk("midrst_if_valid", 64'(IF_valid_o), 64'd0);
        chk("midrst_req_valid", 64'(imem_req_valid_o), 64'd0);
`ifdef IF_PERF_CNT_EN
        chk("midrst_perf_fetch", 64'(perf_fetch_cnt_o), 64'd0);
        chk("midrst_perf_flush", 64'(perf_flush_cnt_o), 64'd0);
`endif
        rst_v = 1'b0; id_rdy = 1'b1;
        step();
        chk("post_rst_req_valid", 64'(imem_req_valid_o), 64'd1);
        chk("post_rst_req_pc", imem_req_pc_o, RST_PC);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
